// File: rtl/power_pkg.sv
// Shared power-mode encodings, sequencer state type and the one-hot check
// used by the power_mode_sequencer slice.
package power_pkg;

  localparam logic [2:0] PWR_OFF   = 3'b000;
  localparam logic [2:0] PWR_TRAIN = 3'b001;
  localparam logic [2:0] PWR_DUEL  = 3'b010;
  localparam logic [2:0] PWR_BULK  = 3'b100;

  typedef enum logic [1:0] {
    ST_OFF    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_RAMP   = 2'd2,
    ST_ACTIVE = 2'd3
  } state_t;

  function automatic logic is_onehot3(input logic [2:0] v);
    return (v == PWR_TRAIN) || (v == PWR_DUEL) || (v == PWR_BULK);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: the lowest request at or above the pointer
// wins (wrapping), and the pointer suggestion is winner+1 mod N.
module rr_arbiter #(
  parameter int N  = 3,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [PW-1:0] i_ptr,
  output logic [N-1:0]  o_gnt,
  output logic          o_vld,
  output logic [PW-1:0] o_nxt_ptr
);

  always_comb begin
    int best_d;
    int best;
    int d;
    best_d    = N;
    best      = 0;
    d         = 0;
    o_gnt     = '0;
    o_vld     = 1'b0;
    o_nxt_ptr = i_ptr;
    // distance from the pointer decides priority, so no variable indexing is needed
    for (int i = 0; i < N; i++) begin
      if (i_req[i]) begin
        d = (i >= int'(i_ptr)) ? i - int'(i_ptr) : i + N - int'(i_ptr);
        if (d < best_d) begin
          best_d = d;
          best   = i;
        end
      end
    end
    for (int i = 0; i < N; i++) begin
      if (best_d < N && best == i) begin
        o_gnt[i]  = 1'b1;
        o_vld     = 1'b1;
        o_nxt_ptr = (i == N - 1) ? '0 : PW'(i + 1);
      end
    end
  end

endmodule

// File: rtl/power_mode_sequencer.sv
// Arbitrates power-mode requests and sequences drain/ramp of the shared
// one-hot power-setting register. Optional feature: BULKHEAD_PREEMPT_EN.
module power_mode_sequencer
  import power_pkg::*;
#(
  parameter int NREQ       = 3,
  parameter int DRAIN_CYC  = 4,
  parameter int SETTLE_CYC = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [NREQ-1:0]   i_req,
  input  logic [3*NREQ-1:0] i_req_mode,
  output logic [NREQ-1:0]   o_gnt,
  output logic [NREQ-1:0]   o_rej,
  output logic [2:0]        o_pow_set,
  output logic              o_pow_ready,
  output logic              o_busy
);

  localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CMAX = (DRAIN_CYC > SETTLE_CYC) ? DRAIN_CYC : SETTLE_CYC;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [CW-1:0] DRAIN_LD  = CW'(DRAIN_CYC - 1);
  localparam logic [CW-1:0] SETTLE_LD = CW'(SETTLE_CYC - 1);

  logic [NREQ-1:0] w_elig, w_arb_req, w_win;
  logic            w_win_vld, w_preempt;
  logic [PW-1:0]   w_nxt_ptr;
  logic [2:0]      w_win_mode;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [PW-1:0]   r_ptr;
  logic [2:0]      r_target, r_pow_set;
  logic [NREQ-1:0] r_gnt, r_rej;
  logic            r_pow_ready, r_busy;

  always_comb begin
    w_elig = '0;
    for (int i = 0; i < NREQ; i++)
      w_elig[i] = i_req[i] & is_onehot3(i_req_mode[3*i +: 3]);
  end

  always_comb begin
    w_win_mode = PWR_OFF;
    for (int i = 0; i < NREQ; i++)
      if (w_win[i]) w_win_mode = w_win_mode | i_req_mode[3*i +: 3];
  end

`ifdef BULKHEAD_PREEMPT_EN
  logic [NREQ-1:0] w_bulk;
  always_comb begin
    w_bulk = '0;
    for (int i = 0; i < NREQ; i++)
      w_bulk[i] = w_elig[i] & (i_req_mode[3*i +: 3] == PWR_BULK);
  end
  assign w_arb_req = (|w_bulk) ? w_bulk : w_elig;
  // r_busy is high exactly in DRAIN/RAMP; a bulkhead target is never aborted
  assign w_preempt = r_busy & (|w_bulk) & (r_target != PWR_BULK);
`else
  assign w_arb_req = w_elig;
  assign w_preempt = 1'b0;
`endif

  rr_arbiter #(.N(NREQ), .PW(PW)) u_arb (
    .i_req     (w_arb_req),
    .i_ptr     (r_ptr),
    .o_gnt     (w_win),
    .o_vld     (w_win_vld),
    .o_nxt_ptr (w_nxt_ptr)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_OFF;
      r_cnt       <= '0;
      r_ptr       <= '0;
      r_target    <= PWR_OFF;
      r_pow_set   <= PWR_OFF;
      r_gnt       <= '0;
      r_rej       <= '0;
      r_pow_ready <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_gnt <= '0;
      r_rej <= i_req & ~w_elig;
      case (r_state)
        ST_OFF: if (w_win_vld) begin
          r_gnt     <= w_win;
          r_ptr     <= w_nxt_ptr;
          r_target  <= w_win_mode;
          r_pow_set <= w_win_mode;
          r_busy    <= 1'b1;
          r_cnt     <= SETTLE_LD;
          r_state   <= ST_RAMP;
        end
        ST_ACTIVE: if (w_win_vld) begin
          r_gnt <= w_win;
          r_ptr <= w_nxt_ptr;
          if (w_win_mode != r_pow_set) begin
            r_target    <= w_win_mode;
            r_pow_set   <= PWR_OFF;
            r_pow_ready <= 1'b0;
            r_busy      <= 1'b1;
            r_cnt       <= DRAIN_LD;
            r_state     <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          // a retarget keeps the drain count running
          if (w_preempt) begin
            r_gnt    <= w_win;
            r_ptr    <= w_nxt_ptr;
            r_target <= PWR_BULK;
          end
          if (r_cnt == '0) begin
            r_pow_set <= w_preempt ? PWR_BULK : r_target;
            r_cnt     <= SETTLE_LD;
            r_state   <= ST_RAMP;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        ST_RAMP: begin
          if (w_preempt) begin
            r_gnt     <= w_win;
            r_ptr     <= w_nxt_ptr;
            r_target  <= PWR_BULK;
            r_pow_set <= PWR_OFF;
            r_cnt     <= DRAIN_LD;
            r_state   <= ST_DRAIN;
          end else if (r_cnt == '0) begin
            r_pow_ready <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= ST_ACTIVE;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        default: r_state <= ST_OFF;
      endcase
    end
  end

  assign o_gnt       = r_gnt;
  assign o_rej       = r_rej;
  assign o_pow_set   = r_pow_set;
  assign o_pow_ready = r_pow_ready;
  assign o_busy      = r_busy;

endmodule
